// File: rtl/bft_t_switch_pkg.sv
// Shared defaults, port indices and packet helper for the BFT NoC.
// Used by noc_if, noc_vc_fifo and bft_t_switch.
package common_pkg;

    localparam int DEFAULT_N             = 16;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 32;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    localparam int DEFAULT_A_W           = $clog2(DEFAULT_N) + 1;
    localparam int NUM_PORTS             = 3;

    typedef enum logic [1:0] {
        PORT_L  = 2'd0,
        PORT_R  = 2'd1,
        PORT_U0 = 2'd2
    } port_e;

    function automatic logic [DEFAULT_A_W+DEFAULT_D_W-1:0] make_packet(
        input logic [DEFAULT_A_W-1:0] addr,
        input logic [DEFAULT_D_W-1:0] data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/noc_if.sv
// Credit-flow-controlled link between two BFT nodes.
// vc_target is one-hot; vc_credit_gnt pulses once per freed slot.
interface noc_if
    import common_pkg::*;
#(
    parameter int A_W  = DEFAULT_A_W,
    parameter int D_W  = DEFAULT_D_W,
    parameter int VC_W = DEFAULT_VC_W
);
    logic [VC_W-1:0]    vc_target;
    logic [A_W+D_W-1:0] packet;
    logic [VC_W-1:0]    vc_credit_gnt;

    modport transmitter (
        output vc_target,
        output packet,
        input  vc_credit_gnt
    );

    modport receiver (
        input  vc_target,
        input  packet,
        output vc_credit_gnt
    );
endinterface

// File: rtl/noc_vc_fifo.sv
// Circular buffer with one slot kept empty to tell full from empty.
// A push while full is ignored.
module noc_vc_fifo
    import common_pkg::*;
#(
    parameter int W     = DEFAULT_A_W + DEFAULT_D_W,
    parameter int DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (inc(wr_ptr) == rd_ptr);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= inc(wr_ptr);
            if (pop && !empty) rd_ptr <= inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bft_t_switch.sv
// Three-port BFT T-switch: per-(port,VC) input FIFOs, credit-checked outputs.
// Define BFT_T_SWITCH_ASSERT_EN to compile in protocol assertions.
module bft_t_switch
    import common_pkg::*;
#(
    parameter int N             = DEFAULT_N,
    parameter int A_W           = $clog2(N) + 1,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int D_W           = DEFAULT_D_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int FAIR_VC_ARB   = 0,
    parameter int posl          = 0,
    parameter int posx          = 0
) (
    input logic      clk,
    input logic      rst,
    noc_if.receiver    l_rx,
    noc_if.transmitter l_tx,
    noc_if.receiver    r_rx,
    noc_if.transmitter r_tx,
    noc_if.receiver    u0_rx,
    noc_if.transmitter u0_tx
);
    localparam int L    = $clog2(N);
    localparam int NP   = NUM_PORTS;
    localparam int P_W  = A_W + D_W;
    localparam int VI_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam int C_W  = (VC_FIFO_DEPTH > 2) ? $clog2(VC_FIFO_DEPTH) : 1;
    localparam logic [C_W-1:0] C_MAX = C_W'(VC_FIFO_DEPTH - 1);

    logic [VC_W-1:0] rx_vc    [NP];
    logic [P_W-1:0]  rx_pkt   [NP];
    logic [VC_W-1:0] tx_cred  [NP];
    logic [VC_W-1:0] empty    [NP];
    logic [VC_W-1:0] full     [NP];
    logic [VC_W-1:0] pop      [NP];
    logic [P_W-1:0]  head     [NP][VC_W];
    logic [NP-1:0]   req      [NP][VC_W];
    logic [VC_W-1:0] vc_sel   [NP];
    logic [NP-1:0]   in_sel   [NP];
    logic            send     [NP];
    logic [P_W-1:0]  pkt_sel  [NP];
    logic [VI_W-1:0] vc_nxt   [NP];
    logic [1:0]      in_nxt   [NP];
    logic [C_W-1:0]  credit   [NP][VC_W];
    logic [VI_W-1:0] vc_ptr   [NP];
    logic [1:0]      in_ptr   [NP];
    logic [VC_W-1:0] tx_vc_q  [NP];
    logic [P_W-1:0]  tx_pkt_q [NP];
    logic [VC_W-1:0] gnt_q    [NP];

    assign rx_vc[0]  = l_rx.vc_target;
    assign rx_vc[1]  = r_rx.vc_target;
    assign rx_vc[2]  = u0_rx.vc_target;
    assign rx_pkt[0] = l_rx.packet;
    assign rx_pkt[1] = r_rx.packet;
    assign rx_pkt[2] = u0_rx.packet;
    assign tx_cred[0] = l_tx.vc_credit_gnt;
    assign tx_cred[1] = r_tx.vc_credit_gnt;
    assign tx_cred[2] = u0_tx.vc_credit_gnt;

    assign l_tx.vc_target  = tx_vc_q[0];
    assign r_tx.vc_target  = tx_vc_q[1];
    assign u0_tx.vc_target = tx_vc_q[2];
    assign l_tx.packet     = tx_pkt_q[0];
    assign r_tx.packet     = tx_pkt_q[1];
    assign u0_tx.packet    = tx_pkt_q[2];
    assign l_rx.vc_credit_gnt  = gnt_q[0];
    assign r_rx.vc_credit_gnt  = gnt_q[1];
    assign u0_rx.vc_credit_gnt = gnt_q[2];

    for (genvar p = 0; p < NP; p++) begin : g_in
        for (genvar v = 0; v < VC_W; v++) begin : g_vc
            noc_vc_fifo #(
                .W     (P_W),
                .DEPTH (VC_FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (rx_vc[p][v] && !full[p][v]),
                .din   (rx_pkt[p]),
                .pop   (pop[p][v]),
                .head  (head[p][v]),
                .empty (empty[p][v]),
                .full  (full[p][v])
            );
        end
    end

    // Upper leaf bits must match posx for the packet to stay in this subtree.
    function automatic logic [1:0] route(
        input logic           from_up,
        input logic [A_W-1:0] addr
    );
        logic [L-1:0] leaf;
        leaf = addr[L-1:0];
        if (!from_up &&
            (addr[A_W-1] || (leaf >> (posl + 1)) != L'(posx)))
            return 2'(PORT_U0);
        return addr[posl] ? 2'(PORT_R) : 2'(PORT_L);
    endfunction

    function automatic logic [31:0] rr_pick(
        input logic [31:0] vec,
        input int          ptr,
        input int          n
    );
        logic [31:0] res;
        int          idx;
        res = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (res == '0 && vec[idx[4:0]]) res[idx[4:0]] = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        req = '{default: '0};
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < VC_W; v++) begin
                for (int o = 0; o < NP; o++) begin
                    if (!empty[p][v] &&
                        route(p == NP - 1, head[p][v][P_W-1 -: A_W]) == o[1:0])
                        req[o][v][p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [VC_W-1:0] elig;
        logic [NP-1:0]   in_req;
        logic [31:0]     pick;
        pop     = '{default: '0};
        vc_sel  = '{default: '0};
        in_sel  = '{default: '0};
        send    = '{default: 1'b0};
        pkt_sel = '{default: '0};
        vc_nxt  = '{default: '0};
        in_nxt  = '{default: '0};
        for (int o = 0; o < NP; o++) begin
            elig = '0;
            for (int v = 0; v < VC_W; v++)
                elig[v] = (|req[o][v]) && (credit[o][v] != '0);
            pick = rr_pick(32'(elig),
                           (FAIR_VC_ARB != 0) ? int'(vc_ptr[o]) : 0, VC_W);
            vc_sel[o] = pick[VC_W-1:0];
            in_req = '0;
            for (int v = 0; v < VC_W; v++)
                if (vc_sel[o][v]) in_req = req[o][v];
            pick = rr_pick(32'(in_req), int'(in_ptr[o]), NP);
            in_sel[o] = pick[NP-1:0];
            send[o] = |in_sel[o];
            for (int p = 0; p < NP; p++) begin
                for (int v = 0; v < VC_W; v++) begin
                    if (in_sel[o][p] && vc_sel[o][v]) begin
                        pkt_sel[o] = head[p][v];
                        pop[p][v]  = 1'b1;
                    end
                end
            end
            for (int v = 0; v < VC_W; v++)
                if (vc_sel[o][v]) vc_nxt[o] = VI_W'((v + 1) % VC_W);
            for (int p = 0; p < NP; p++)
                if (in_sel[o][p]) in_nxt[o] = 2'((p + 1) % NP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NP; o++) begin
                tx_vc_q[o]  <= '0;
                tx_pkt_q[o] <= '0;
                vc_ptr[o]   <= '0;
                in_ptr[o]   <= '0;
                gnt_q[o]    <= '0;
                for (int v = 0; v < VC_W; v++) credit[o][v] <= C_MAX;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                tx_vc_q[o] <= send[o] ? vc_sel[o] : '0;
                gnt_q[o]   <= pop[o];
                if (send[o]) begin
                    tx_pkt_q[o] <= pkt_sel[o];
                    in_ptr[o]   <= in_nxt[o];
                    if (FAIR_VC_ARB != 0) vc_ptr[o] <= vc_nxt[o];
                end
                for (int v = 0; v < VC_W; v++) begin
                    if (vc_sel[o][v] && !tx_cred[o][v])
                        credit[o][v] <= credit[o][v] - C_W'(1);
                    else if (tx_cred[o][v] && !vc_sel[o][v])
                        credit[o][v] <= credit[o][v] + C_W'(1);
                end
            end
        end
    end

`ifdef BFT_T_SWITCH_ASSERT_EN
    always_ff @(posedge clk) begin
        assert ((N & (N - 1)) == 0) else $error("N=%0d not a power of 2", N);
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                assert ($onehot0(rx_vc[p]))
                    else $error("port %0d vc_target not one-hot", p);
                for (int v = 0; v < VC_W; v++)
                    assert (!(rx_vc[p][v] && full[p][v]))
                        else $error("write to full fifo p%0d vc%0d", p, v);
            end
            for (int o = 0; o < NP; o++) begin
                for (int v = 0; v < VC_W; v++) begin
                    assert (!(vc_sel[o][v] && credit[o][v] == '0))
                        else $error("send without credit o%0d vc%0d", o, v);
                    assert (!(tx_cred[o][v] && !vc_sel[o][v] &&
                              credit[o][v] == C_MAX))
                        else $error("credit overflow o%0d vc%0d", o, v);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_bft_t_switch.sv
// Scoreboard bench for bft_t_switch (N=8, posl=0, posx=1).
// dut0 uses fixed VC priority, dut1 round-robin VC choice.
module tb_bft_t_switch;
    import common_pkg::*;

    localparam int PW = 36;

    typedef struct {
        logic [1:0]    vc;
        logic [PW-1:0] pkt;
        int            lo;
        int            hi;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    logic [1:0]    in_vc   [2][3];
    logic [PW-1:0] in_pkt  [2][3];
    logic [1:0]    out_vc  [2][3];
    logic [PW-1:0] out_pkt [2][3];
    logic [1:0]    ret_gnt [2][3];
    logic [1:0]    rx_gnt  [2][3];
    logic [1:0]    man_gnt [2][3];
    bit            hold    [2][3];
    int            cred_cnt[3];
    exp_t          q       [2][3][$];

    noc_if #(.A_W(4), .D_W(32), .VC_W(2)) rx0 [3] ();
    noc_if #(.A_W(4), .D_W(32), .VC_W(2)) tx0 [3] ();
    noc_if #(.A_W(4), .D_W(32), .VC_W(2)) rx1 [3] ();
    noc_if #(.A_W(4), .D_W(32), .VC_W(2)) tx1 [3] ();

    for (genvar i = 0; i < 3; i++) begin : g_wire
        assign rx0[i].vc_target     = in_vc[0][i];
        assign rx0[i].packet        = in_pkt[0][i];
        assign rx1[i].vc_target     = in_vc[1][i];
        assign rx1[i].packet        = in_pkt[1][i];
        assign tx0[i].vc_credit_gnt = ret_gnt[0][i];
        assign tx1[i].vc_credit_gnt = ret_gnt[1][i];
        assign out_vc[0][i]  = tx0[i].vc_target;
        assign out_pkt[0][i] = tx0[i].packet;
        assign out_vc[1][i]  = tx1[i].vc_target;
        assign out_pkt[1][i] = tx1[i].packet;
        assign rx_gnt[0][i]  = rx0[i].vc_credit_gnt;
        assign rx_gnt[1][i]  = rx1[i].vc_credit_gnt;
    end

    bft_t_switch #(
        .N(8), .A_W(4), .VC_W(2), .D_W(32), .VC_FIFO_DEPTH(4),
        .FAIR_VC_ARB(0), .posl(0), .posx(1)
    ) dut0 (
        .clk(clk), .rst(rst),
        .l_rx(rx0[0]), .l_tx(tx0[0]),
        .r_rx(rx0[1]), .r_tx(tx0[1]),
        .u0_rx(rx0[2]), .u0_tx(tx0[2])
    );

    bft_t_switch #(
        .N(8), .A_W(4), .VC_W(2), .D_W(32), .VC_FIFO_DEPTH(4),
        .FAIR_VC_ARB(1), .posl(0), .posx(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .l_rx(rx1[0]), .l_tx(tx1[0]),
        .r_rx(rx1[1]), .r_tx(tx1[1]),
        .u0_rx(rx1[2]), .u0_tx(tx1[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] mk(input int addr, input int data);
        return {4'(addr), 32'(data)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) in_vc[d][i] = 2'b00;
    endtask

    task automatic drive(input int d, input int p, input logic [1:0] vc,
                         input int addr, input int data);
        in_vc[d][p]  = vc;
        in_pkt[d][p] = mk(addr, data);
    endtask

    task automatic expect_out(input int d, input int o, input logic [1:0] vc,
                              input int addr, input int data,
                              input int lo, input int hi);
        exp_t e;
        e.vc  = vc;
        e.pkt = mk(addr, data);
        e.lo  = lo;
        e.hi  = hi;
        q[d][o].push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!rst && out_vc[d][i] != 2'b00) begin
                        checks++;
                        if (q[d][i].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_out d%0d p%0d: got vc=%b pkt=%h at %0d want none",
                                     d, i, out_vc[d][i], out_pkt[d][i], cyc);
                        end else begin
                            e = q[d][i].pop_front();
                            if (out_vc[d][i] != e.vc || out_pkt[d][i] != e.pkt ||
                                cyc < e.lo || cyc > e.hi) begin
                                errors++;
                                $display("FAIL out d%0d p%0d: got vc=%b pkt=%h cyc=%0d want vc=%b pkt=%h cyc=%0d..%0d",
                                         d, i, out_vc[d][i], out_pkt[d][i], cyc,
                                         e.vc, e.pkt, e.lo, e.hi);
                            end
                        end
                    end
                    ret_gnt[d][i] = (hold[d][i] ? 2'b00 : out_vc[d][i]) | man_gnt[d][i];
                    if (d == 0 && !rst)
                        cred_cnt[i] += int'(rx_gnt[0][i][0]) + int'(rx_gnt[0][i][1]);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int t;
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                in_vc[d][i]   = 2'b00;
                in_pkt[d][i]  = '0;
                ret_gnt[d][i] = 2'b00;
                man_gnt[d][i] = 2'b00;
                hold[d][i]    = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) cred_cnt[i] = 0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++)
                chk($sformatf("reset_d%0d_p%0d", d, i),
                    {out_vc[d][i], rx_gnt[d][i], out_pkt[d][i]}, 64'd0);
        rst = 1'b0;
        tick();

        // 1: l_rx -> r_tx, exact two-cycle latency and credit return
        t = cyc;
        drive(0, 0, 2'b01, 3, 32'hA0A0_0001);
        expect_out(0, 1, 2'b01, 3, 32'hA0A0_0001, t + 2, t + 2);
        tick();
        tick();
        chk("s1_l_gnt", rx_gnt[0][0], 2'b01);
        chk("s1_r_gnt", rx_gnt[0][1], 2'b00);
        chk("s1_u0_gnt", rx_gnt[0][2], 2'b00);
        chk("s1_l_tx", out_vc[0][0], 2'b00);
        chk("s1_u0_tx", out_vc[0][2], 2'b00);
        repeat (3) tick();

        // 2: out-of-subtree goes up, from parent goes down
        t = cyc;
        drive(0, 0, 2'b01, 5, 32'hB0B0_0002);
        expect_out(0, 2, 2'b01, 5, 32'hB0B0_0002, t + 2, t + 2);
        tick();
        drive(0, 2, 2'b10, 2, 32'hC0C0_0003);
        expect_out(0, 0, 2'b10, 2, 32'hC0C0_0003, t + 3, t + 3);
        tick();
        repeat (3) tick();

        // 3: root address goes up unchanged
        t = cyc;
        drive(0, 1, 2'b01, 8, 32'hD0D0_0004);
        expect_out(0, 2, 2'b01, 8, 32'hD0D0_0004, t + 2, t + 2);
        tick();
        repeat (3) tick();

        // 4: no credit return on r_tx vc1: fourth flit waits
        hold[0][1] = 1'b1;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 2'b10, 3, 32'hE000_0000 + k);
            if (k < 3)
                expect_out(0, 1, 2'b10, 3, 32'hE000_0000 + k,
                           t + k + 2, t + k + 2);
            tick();
        end
        repeat (8) tick();
        chk("s4_three_delivered", 64'(q[0][1].size()), 64'd0);
        man_gnt[0][1] = 2'b10;
        t = cyc;
        expect_out(0, 1, 2'b10, 3, 32'hE000_0003, t + 1, t + 2);
        tick();
        man_gnt[0][1] = 2'b00;
        repeat (5) tick();
        hold[0][1] = 1'b0;
        chk("s4_fourth_delivered", 64'(q[0][1].size()), 64'd0);
        chk("cred_l_a", 64'(cred_cnt[0]), 64'd6);
        chk("cred_r_a", 64'(cred_cnt[1]), 64'd1);
        chk("cred_u0_a", 64'(cred_cnt[2]), 64'd1);

        do_reset();
        for (int i = 0; i < 3; i++) cred_cnt[i] = 0;

        // 5: l and u0 contend for r_tx vc0: alternate l, u0
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            expect_out(0, 1, 2'b01, 3, 32'hF100_0000 + k,
                       t + 2 + 2 * k, t + 2 + 2 * k);
            expect_out(0, 1, 2'b01, 3, 32'hF200_0000 + k,
                       t + 3 + 2 * k, t + 3 + 2 * k);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 2'b01, 3, 32'hF100_0000 + k);
            drive(0, 2, 2'b01, 3, 32'hF200_0000 + k);
            tick();
        end
        repeat (8) tick();
        chk("s5_drained", 64'(q[0][1].size()), 64'd0);

        // 6: vc0 and vc1 backlogged toward u0 on both switches
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            expect_out(1, 2, 2'b01, 5, 32'h6100_0000 + k,
                       t + 2 + 2 * k, t + 2 + 2 * k);
            expect_out(1, 2, 2'b10, 6, 32'h6200_0000 + k,
                       t + 3 + 2 * k, t + 3 + 2 * k);
        end
        for (int k = 0; k < 3; k++)
            expect_out(0, 2, 2'b01, 5, 32'h6100_0000 + k, t + 2 + k, t + 2 + k);
        for (int k = 0; k < 3; k++)
            expect_out(0, 2, 2'b10, 6, 32'h6200_0000 + k, t + 5 + k, t + 5 + k);
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 0, 2'b01, 5, 32'h6100_0000 + k);
                drive(d, 1, 2'b10, 6, 32'h6200_0000 + k);
            end
            tick();
        end
        repeat (10) tick();

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++)
                chk($sformatf("final_empty_d%0d_p%0d", d, i),
                    64'(q[d][i].size()), 64'd0);
        chk("cred_l_b", 64'(cred_cnt[0]), 64'd6);
        chk("cred_r_b", 64'(cred_cnt[1]), 64'd3);
        chk("cred_u0_b", 64'(cred_cnt[2]), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
